ub_access_scheduler: RTL and testbench

- Sequences all accesses to the unified buffer (UB).
- Accepts one command at a time from the instruction decoder: a READ burst, or a WRITE burst sourced from either the host loader or the VPU writeback.
- Generates per-cycle UB addresses and lane valids. Muxes the selected write source onto the UB write port and gates the unselected one.
- Sits between the decoder, the two write requesters and the UB. The UB itself only sees flat address/data/valid per lane.

---
 rtl/ub_access_scheduler_if.sv | 75 +++++++
 rtl/ub_access_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_ub_access_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ub_access_scheduler_if.sv
// ---------------------------------------------------------------------------
// ub_access_scheduler_if
// Bundle of every signal between the unified-buffer access scheduler and its
// neighbours: the decoder command channel, the two write requesters (host
// loader and VPU writeback), the flat UB read/write ports and the status
// pulses.
//
//   modport slave  : the scheduler side (takes command and requester data,
//                    drives UB ports and status)
//   modport master : the environment side (decoder, requesters, UB, monitor)
//
// Parameters: ADDR_W (address/length width), DATA_W (lane data width).
// ---------------------------------------------------------------------------
interface ub_access_scheduler_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    // command channel
    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic [1:0]        cmd_op_in;
    logic [ADDR_W-1:0] cmd_addr_in;
    logic [ADDR_W-1:0] cmd_len_in;

    // host loader write source
    logic [DATA_W-1:0] host_data_1_in;
    logic [DATA_W-1:0] host_data_2_in;
    logic              host_valid_1_in;
    logic              host_valid_2_in;

    // VPU writeback write source
    logic [DATA_W-1:0] vpu_data_1_in;
    logic [DATA_W-1:0] vpu_data_2_in;
    logic              vpu_valid_1_in;
    logic              vpu_valid_2_in;

    // UB read port
    logic [ADDR_W-1:0] ub_rd_addr_out;
    logic              ub_rd_valid_1_out;
    logic              ub_rd_valid_2_out;

    // UB write port
    logic [ADDR_W-1:0] ub_wr_addr_out;
    logic [DATA_W-1:0] ub_wr_data_1_out;
    logic [DATA_W-1:0] ub_wr_data_2_out;
    logic              ub_wr_valid_1_out;
    logic              ub_wr_valid_2_out;

    // status
    logic              busy_out;
    logic              done_out;
    logic              err_out;

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_addr_in, cmd_len_in,
        input  host_data_1_in, host_data_2_in, host_valid_1_in, host_valid_2_in,
        input  vpu_data_1_in, vpu_data_2_in, vpu_valid_1_in, vpu_valid_2_in,
        output cmd_ready_out,
        output ub_rd_addr_out, ub_rd_valid_1_out, ub_rd_valid_2_out,
        output ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out,
        output ub_wr_valid_1_out, ub_wr_valid_2_out,
        output busy_out, done_out, err_out
    );

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_addr_in, cmd_len_in,
        output host_data_1_in, host_data_2_in, host_valid_1_in, host_valid_2_in,
        output vpu_data_1_in, vpu_data_2_in, vpu_valid_1_in, vpu_valid_2_in,
        input  cmd_ready_out,
        input  ub_rd_addr_out, ub_rd_valid_1_out, ub_rd_valid_2_out,
        input  ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out,
        input  ub_wr_valid_1_out, ub_wr_valid_2_out,
        input  busy_out, done_out, err_out
    );
endinterface

// File: rtl/ub_access_scheduler.sv
// ---------------------------------------------------------------------------
// ub_access_scheduler
// Sequences every unified-buffer access. Takes one command at a time from the
// decoder (READ burst, or WRITE burst from host loader or VPU writeback),
// generates per-cycle UB addresses and lane valids, and muxes the selected
// write source onto the UB write port while ignoring the other source.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (priority over everything)
//   bus  : ub_access_scheduler_if.slave -- command channel, host/VPU write
//          sources, UB read/write ports, busy/done/err status
// Optional (macro UB_SCHED_PERF_EN defined):
//   perf_rd_words_out    : saturating count of UB words read
//   perf_wr_words_out    : saturating count of UB words written
//   perf_busy_cycles_out : saturating count of cycles with busy_out high
//
// All interface outputs are registered. Commands: op 00 READ, 01 WRITE_HOST,
// 10 WRITE_VPU, 11 reserved (rejected). Lane 2 always addresses lane-1 + 1.
// ---------------------------------------------------------------------------
module ub_access_scheduler #(
    parameter int UB_DEPTH = 50,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ub_access_scheduler_if.slave   bus
`ifdef UB_SCHED_PERF_EN
    ,
    output logic [15:0]            perf_rd_words_out,
    output logic [15:0]            perf_wr_words_out,
    output logic [15:0]            perf_busy_cycles_out
`endif
);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(UB_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [ADDR_W-1:0] rem, rem_nx;
    logic              src_vpu, src_vpu_nx;  // 1: VPU is the write source
    logic              ovf, ovf_nx;          // lane dropped; report with done

    logic [ADDR_W-1:0] rd_addr_nx;
    logic              rd_v1_nx, rd_v2_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [DATA_W-1:0] wr_d1_nx, wr_d2_nx;
    logic              wr_v1_nx, wr_v2_nx;
    logic              done_nx, err_nx;

    // selected write source after gating
    logic              sel_v1, sel_v2;
    logic [DATA_W-1:0] sel_d1, sel_d2;
    logic [ADDR_W:0]   cmd_end;
    logic              cmd_bad;

    function automatic logic [ADDR_W-1:0] sat_sub(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] c,
                                              input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, c} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign sel_v1 = src_vpu ? bus.vpu_valid_1_in : bus.host_valid_1_in;
    assign sel_v2 = src_vpu ? bus.vpu_valid_2_in : bus.host_valid_2_in;
    assign sel_d1 = src_vpu ? bus.vpu_data_1_in  : bus.host_data_1_in;
    assign sel_d2 = src_vpu ? bus.vpu_data_2_in  : bus.host_data_2_in;

    // one extra bit so addr+len cannot wrap before the range check
    assign cmd_end = {1'b0, bus.cmd_addr_in} + {1'b0, bus.cmd_len_in};
    assign cmd_bad = (bus.cmd_op_in == OP_RSVD) || (cmd_end > DEPTH_L);

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        rem_nx     = rem;
        src_vpu_nx = src_vpu;
        ovf_nx     = ovf;
        rd_addr_nx = '0;
        rd_v1_nx   = 1'b0;
        rd_v2_nx   = 1'b0;
        wr_addr_nx = '0;
        wr_d1_nx   = '0;
        wr_d2_nx   = '0;
        wr_v1_nx   = 1'b0;
        wr_v2_nx   = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid_in && bus.cmd_ready_out) begin
                    if (cmd_bad) begin
                        err_nx = 1'b1;
                    end else if (bus.cmd_len_in == '0) begin
                        done_nx = 1'b1;
                    end else if (bus.cmd_op_in == OP_READ) begin
                        // first read beat goes out on the cycle after acceptance
                        rd_addr_nx = bus.cmd_addr_in;
                        rd_v1_nx   = 1'b1;
                        rd_v2_nx   = (bus.cmd_len_in >= ADDR_W'(2));
                        ptr_nx     = bus.cmd_addr_in + ADDR_W'(2);
                        rem_nx     = sat_sub(bus.cmd_len_in, ADDR_W'(2));
                        state_nx   = RD;
                    end else begin
                        ptr_nx     = bus.cmd_addr_in;
                        rem_nx     = bus.cmd_len_in;
                        src_vpu_nx = bus.cmd_op_in[1];
                        ovf_nx     = 1'b0;
                        state_nx   = WR;
                    end
                end
            end

            RD: begin
                if (rem == '0) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    rd_addr_nx = ptr;
                    rd_v1_nx   = 1'b1;
                    rd_v2_nx   = (rem >= ADDR_W'(2));
                    ptr_nx     = ptr + ADDR_W'(2);
                    rem_nx     = sat_sub(rem, ADDR_W'(2));
                end
            end

            WR: begin
                if (rem == '0) begin
                    done_nx  = 1'b1;
                    err_nx   = ovf;
                    ovf_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    wr_addr_nx = ptr;
                    if (sel_v1 && sel_v2) begin
                        wr_v1_nx = 1'b1;
                        wr_d1_nx = sel_d1;
                        if (rem == ADDR_W'(1)) begin
                            // only one word of room left: lane 2 is dropped
                            ptr_nx = ptr + ADDR_W'(1);
                            rem_nx = '0;
                            ovf_nx = 1'b1;
                        end else begin
                            wr_v2_nx = 1'b1;
                            wr_d2_nx = sel_d2;
                            ptr_nx   = ptr + ADDR_W'(2);
                            rem_nx   = rem - ADDR_W'(2);
                        end
                    end else if (sel_v1 || sel_v2) begin
                        // a lone lane is packed onto lane 1 so words stay contiguous
                        wr_v1_nx = 1'b1;
                        wr_d1_nx = sel_v1 ? sel_d1 : sel_d2;
                        ptr_nx   = ptr + ADDR_W'(1);
                        rem_nx   = rem - ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            ptr                   <= '0;
            rem                   <= '0;
            src_vpu               <= 1'b0;
            ovf                   <= 1'b0;
            bus.cmd_ready_out     <= 1'b1;
            bus.busy_out          <= 1'b0;
            bus.done_out          <= 1'b0;
            bus.err_out           <= 1'b0;
            bus.ub_rd_addr_out    <= '0;
            bus.ub_rd_valid_1_out <= 1'b0;
            bus.ub_rd_valid_2_out <= 1'b0;
            bus.ub_wr_addr_out    <= '0;
            bus.ub_wr_data_1_out  <= '0;
            bus.ub_wr_data_2_out  <= '0;
            bus.ub_wr_valid_1_out <= 1'b0;
            bus.ub_wr_valid_2_out <= 1'b0;
        end else begin
            state                 <= state_nx;
            ptr                   <= ptr_nx;
            rem                   <= rem_nx;
            src_vpu               <= src_vpu_nx;
            ovf                   <= ovf_nx;
            bus.cmd_ready_out     <= (state_nx == IDLE);
            bus.busy_out          <= (state_nx != IDLE);
            bus.done_out          <= done_nx;
            bus.err_out           <= err_nx;
            bus.ub_rd_addr_out    <= rd_addr_nx;
            bus.ub_rd_valid_1_out <= rd_v1_nx;
            bus.ub_rd_valid_2_out <= rd_v2_nx;
            bus.ub_wr_addr_out    <= wr_addr_nx;
            bus.ub_wr_data_1_out  <= wr_d1_nx;
            bus.ub_wr_data_2_out  <= wr_d2_nx;
            bus.ub_wr_valid_1_out <= wr_v1_nx;
            bus.ub_wr_valid_2_out <= wr_v2_nx;
        end
    end

`ifdef UB_SCHED_PERF_EN
    // counters follow the registered outputs, so they count what the UB saw
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_words_out    <= '0;
            perf_wr_words_out    <= '0;
            perf_busy_cycles_out <= '0;
        end else begin
            perf_rd_words_out    <= sat_add16(perf_rd_words_out,
                                       {1'b0, bus.ub_rd_valid_1_out} + {1'b0, bus.ub_rd_valid_2_out});
            perf_wr_words_out    <= sat_add16(perf_wr_words_out,
                                       {1'b0, bus.ub_wr_valid_1_out} + {1'b0, bus.ub_wr_valid_2_out});
            perf_busy_cycles_out <= sat_add16(perf_busy_cycles_out, {1'b0, bus.busy_out});
        end
    end
`endif

endmodule

// File: tb/tb_ub_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ub_access_scheduler
// Directed bench for ub_access_scheduler: READ bursts (odd/even, end of
// buffer), host and VPU write bursts with lane packing, source gating and
// overflow, rejected commands, zero length, back-to-back commands and
// reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_ub_access_scheduler;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    ub_access_scheduler_if #(.ADDR_W(6), .DATA_W(16)) bus ();

`ifdef UB_SCHED_PERF_EN
    logic [15:0] perf_rd_words;
    logic [15:0] perf_wr_words;
    logic [15:0] perf_busy_cycles;
`endif

    ub_access_scheduler #(.UB_DEPTH(50), .ADDR_W(6), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef UB_SCHED_PERF_EN
        ,
        .perf_rd_words_out    (perf_rd_words),
        .perf_wr_words_out    (perf_wr_words),
        .perf_busy_cycles_out (perf_busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // inputs are driven and outputs sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [5:0] addr, input logic [5:0] len);
        bus.cmd_valid_in = 1'b1;
        bus.cmd_op_in    = op;
        bus.cmd_addr_in  = addr;
        bus.cmd_len_in   = len;
    endtask

    task automatic host(input logic v1, input logic v2, input logic [15:0] d1, input logic [15:0] d2);
        bus.host_valid_1_in = v1;
        bus.host_valid_2_in = v2;
        bus.host_data_1_in  = d1;
        bus.host_data_2_in  = d2;
    endtask

    task automatic vpu(input logic v1, input logic v2, input logic [15:0] d1, input logic [15:0] d2);
        bus.vpu_valid_1_in = v1;
        bus.vpu_valid_2_in = v2;
        bus.vpu_data_1_in  = d1;
        bus.vpu_data_2_in  = d2;
    endtask

    task automatic chk_rd(input string tag, input logic [5:0] a, input logic v1, input logic v2);
        chk({tag, ".v1"}, bus.ub_rd_valid_1_out, v1);
        chk({tag, ".v2"}, bus.ub_rd_valid_2_out, v2);
        if (v1) chk({tag, ".addr"}, bus.ub_rd_addr_out, a);
    endtask

    task automatic chk_wr(input string tag, input logic [5:0] a, input logic v1, input logic v2,
                          input logic [15:0] d1, input logic [15:0] d2);
        chk({tag, ".v1"}, bus.ub_wr_valid_1_out, v1);
        chk({tag, ".v2"}, bus.ub_wr_valid_2_out, v2);
        if (v1) begin
            chk({tag, ".addr"}, bus.ub_wr_addr_out, a);
            chk({tag, ".d1"}, bus.ub_wr_data_1_out, d1);
        end
        if (v2) chk({tag, ".d2"}, bus.ub_wr_data_2_out, d2);
    endtask

    task automatic chk_stat(input string tag, input logic rdy, input logic busy,
                            input logic done, input logic err);
        chk({tag, ".ready"}, bus.cmd_ready_out, rdy);
        chk({tag, ".busy"}, bus.busy_out, busy);
        chk({tag, ".done"}, bus.done_out, done);
        chk({tag, ".err"}, bus.err_out, err);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_op_in    = 2'b00;
        bus.cmd_addr_in  = 6'd0;
        bus.cmd_len_in   = 6'd0;
        host(1'b0, 1'b0, 16'h0, 16'h0);
        vpu(1'b0, 1'b0, 16'h0, 16'h0);

        // reset state
        tick();
        tick();
        chk_stat("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_rd("rst.rd", 6'd0, 1'b0, 1'b0);
        chk_wr("rst.wr", 6'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;
        tick();

        // READ addr=4 len=5: (4,1,1) (6,1,1) (8,1,0) then done
        cmd(2'b00, 6'd4, 6'd5);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_rd("rd5.b1", 6'd4, 1'b1, 1'b1);
        chk_stat("rd5.b1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_rd("rd5.b2", 6'd6, 1'b1, 1'b1);
        tick();
        chk_rd("rd5.b3", 6'd8, 1'b1, 1'b0);
        chk("rd5.b3.busy", bus.busy_out, 1'b1);
        tick();
        chk_rd("rd5.done", 6'd0, 1'b0, 1'b0);
        chk_stat("rd5.done", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rd5.after.done", bus.done_out, 1'b0);

        // WRITE_HOST addr=10 len=4, VPU valids active throughout
        cmd(2'b01, 6'd10, 6'd4);
        vpu(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk("wh.busy", bus.busy_out, 1'b1);
        host(1'b0, 1'b0, 16'h1111, 16'h2222);     // only VPU valid: nothing written
        tick();
        chk_wr("wh.gate", 6'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        host(1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
        vpu(1'b0, 1'b1, 16'hDEAD, 16'hBEEF);
        tick();
        chk_wr("wh.ab", 6'd10, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
        host(1'b0, 1'b1, 16'h5555, 16'hCCCC);
        vpu(1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        tick();
        chk_wr("wh.c", 6'd12, 1'b1, 1'b0, 16'hCCCC, 16'h0);
        host(1'b1, 1'b0, 16'hDDDD, 16'h6666);
        vpu(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
        tick();
        chk_wr("wh.d", 6'd13, 1'b1, 1'b0, 16'hDDDD, 16'h0);
        host(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk_wr("wh.done", 6'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk_stat("wh.done", 1'b1, 1'b0, 1'b1, 1'b0);
        vpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // WRITE_VPU addr=48 len=1 with both lanes: X@48, Y dropped, err+done
        cmd(2'b10, 6'd48, 6'd1);
        tick();
        bus.cmd_valid_in = 1'b0;
        vpu(1'b1, 1'b1, 16'h7777, 16'h8888);
        tick();
        chk_wr("wv.x", 6'd48, 1'b1, 1'b0, 16'h7777, 16'h0);
        vpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk_stat("wv.done", 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("wv.after.err", bus.err_out, 1'b0);

        // READ addr=45 len=6 overruns the buffer: rejected
        cmd(2'b00, 6'd45, 6'd6);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_stat("rej.rng", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_rd("rej.rng.rd", 6'd0, 1'b0, 1'b0);
        tick();
        chk("rej.rng.after", bus.err_out, 1'b0);
        chk_rd("rej.rng.after.rd", 6'd0, 1'b0, 1'b0);

        // reserved op: rejected
        cmd(2'b11, 6'd0, 6'd2);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_stat("rej.op", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_wr("rej.op.wr", 6'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // READ addr=46 len=4 ends exactly at the last word: legal
        cmd(2'b00, 6'd46, 6'd4);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk("edge.err", bus.err_out, 1'b0);
        chk_rd("edge.b1", 6'd46, 1'b1, 1'b1);
        tick();
        chk_rd("edge.b2", 6'd48, 1'b1, 1'b1);
        tick();
        chk_stat("edge.done", 1'b1, 1'b0, 1'b1, 1'b0);

        // READ len=0: done next cycle, no access
        cmd(2'b00, 6'd3, 6'd0);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_stat("len0", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_rd("len0.rd", 6'd0, 1'b0, 1'b0);
        tick();

        // back-to-back: second command offered on the done cycle
        cmd(2'b00, 6'd30, 6'd1);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_rd("b2b.a", 6'd30, 1'b1, 1'b0);
        tick();
        chk_stat("b2b.done", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd(2'b00, 6'd7, 6'd2);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_rd("b2b.b", 6'd7, 1'b1, 1'b1);
        chk("b2b.b.busy", bus.busy_out, 1'b1);
        tick();
        chk("b2b.b.done", bus.done_out, 1'b1);
        tick();

        // reset at beat 2 of READ len=8
        cmd(2'b00, 6'd0, 6'd8);
        tick();
        bus.cmd_valid_in = 1'b0;
        chk_rd("mrst.b1", 6'd0, 1'b1, 1'b1);
        tick();
        chk_rd("mrst.b2", 6'd2, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_stat("mrst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_rd("mrst.rd", 6'd0, 1'b0, 1'b0);
        tick();
        chk_stat("mrst.after", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_rd("mrst.after.rd", 6'd0, 1'b0, 1'b0);

        // new command after reset completes normally
        cmd(2'b01, 6'd5, 6'd2);
        tick();
        bus.cmd_valid_in = 1'b0;
        host(1'b1, 1'b1, 16'h0123, 16'h4567);
        tick();
        chk_wr("post.w", 6'd5, 1'b1, 1'b1, 16'h0123, 16'h4567);
        host(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk_stat("post.done", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // absolute time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
